data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the CPU data-memory port. Models a byte-writable
// data RAM with a programmable number of wait states. The pipeline is held
// with MemStall until each access completes. Completion is signalled by a
// one-cycle MemValid pulse.
//
// Parameters
//   DEPTH        number of 32-bit words (valid word index 0..DEPTH-1)
//   WAIT_CYCLES  extra busy cycles per access (0..15)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset (RAM contents are kept)
//   MemEnable     access request, held by the CPU until MemStall drops
//   MemWen[3:0]   byte-lane write enables, 4'b0000 = read
//   MemAddr[31:0] byte address, word index = MemAddr[31:2]
//   MemWriteData  lane-replicated write data
//   MemReadData   full read word, holds until the next read completes
//   MemStall      MemEnable & not DONE (combinational)
//   MemValid      one-cycle completion pulse
//   MemAddrErr    one-cycle pulse with MemValid for an out-of-range index
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemEnable,
    input  logic [3:0]  MemWen,
    input  logic [31:0] MemAddr,
    input  logic [31:0] MemWriteData,
    output logic [31:0] MemReadData,
    output logic        MemStall,
    output logic        MemValid,
    output logic        MemAddrErr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [29:0] r_idx;
    logic [3:0]  r_wen;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_valid;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic [29:0] w_idx;
    logic [3:0]  w_wen;
    logic [31:0] w_wdata;
    logic        w_in_range;
    logic        w_access;
    logic [AW-1:0] w_ram_idx;
    logic        w_unused;

    // Byte offset bits never select anything: the RAM is word-organised.
    assign w_unused = ^MemAddr[1:0];

    // Access operands: live inputs for a zero-wait access from IDLE,
    // captured copies once the request has moved into BUSY.
    always_comb begin
        w_idx   = MemAddr[31:2];
        w_wen   = MemWen;
        w_wdata = MemWriteData;
        if (r_state == ST_BUSY) begin
            w_idx   = r_idx;
            w_wen   = r_wen;
            w_wdata = r_wdata;
        end else begin
            w_idx   = MemAddr[31:2];
            w_wen   = MemWen;
            w_wdata = MemWriteData;
        end
    end

    assign w_in_range = ({2'b00, w_idx} < 32'(DEPTH));
    assign w_ram_idx  = w_idx[AW-1:0];

    // The RAM is touched on the request edge itself when there are no wait
    // states, otherwise on the last BUSY edge (counter == 1).
    assign w_access = (WAIT_CYCLES == 0)
                    ? ((r_state == ST_IDLE) && MemEnable)
                    : ((r_state == ST_BUSY) && (r_cnt == 4'd1));

    // Byte-lane RAM write port; not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && w_access && w_in_range && (w_wen != 4'b0000)) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wen[i]) begin
                    r_mem[w_ram_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM: capture, wait-state count, read data and completion flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= 30'd0;
            r_wen   <= 4'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (MemEnable) begin
                        r_idx   <= MemAddr[31:2];
                        r_wen   <= MemWen;
                        r_wdata <= MemWriteData;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= 4'(WAIT_CYCLES);
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Completion side effects share the access edge with the RAM write.
            if (w_access) begin
                r_valid <= 1'b1;
                r_err   <= !w_in_range;
                if (w_wen == 4'b0000) begin
                    r_rdata <= w_in_range ? r_mem[w_ram_idx] : 32'd0;
                end
            end
        end
    end

    // Reset masks the handshake outputs immediately, including in DONE.
    assign MemStall    = MemEnable && (r_state != ST_DONE) && !rst;
    assign MemValid    = r_valid && !rst;
    assign MemAddrErr  = r_err && !rst;
    assign MemReadData = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk;
    logic        rst  [2];
    logic        en   [2];
    logic [3:0]  wen  [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [31:0] rd   [2];
    logic        stall[2];
    logic        vld  [2];
    logic        err  [2];

    // Reference model: word array per DUT, last completed read word per DUT.
    logic [31:0] mdl [2][1024];
    logic [31:0] last_rd [2];
    int          wt [2];

    int n_checks;
    int n_errors;

    // u_dut0 has no wait states, u_dut3 has three.
    data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .MemEnable(en[0]), .MemWen(wen[0]),
        .MemAddr(addr[0]), .MemWriteData(wd[0]), .MemReadData(rd[0]),
        .MemStall(stall[0]), .MemValid(vld[0]), .MemAddrErr(err[0])
    );

    data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst[1]), .MemEnable(en[1]), .MemWen(wen[1]),
        .MemAddr(addr[1]), .MemWriteData(wd[1]), .MemReadData(rd[1]),
        .MemStall(stall[1]), .MemValid(vld[1]), .MemAddrErr(err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access; checks latency, stall count, error flag and read data.
    task automatic access(input int d, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] data, input bit hold);
        int          k;
        int          stalls;
        logic [29:0] idx;
        logic        oor;
        @(negedge clk);
        en[d]   = 1'b1;
        wen[d]  = w;
        addr[d] = a;
        wd[d]   = data;
        #1;
        k = 0;
        stalls = 0;
        while (vld[d] !== 1'b1 && k < 40) begin
            if (stall[d] === 1'b1) stalls++;
            @(negedge clk);
            #1;
            k++;
        end
        idx = a[31:2];
        oor = (idx >= 30'd1024);
        chk("latency", 32'(k), 32'(wt[d] + 1));
        chk("stall_cycles", 32'(stalls), 32'(wt[d] + 1));
        chk("stall_in_done", {31'd0, stall[d]}, 32'd0);
        chk("addr_err", {31'd0, err[d]}, {31'd0, oor});
        if (w == 4'b0000) begin
            last_rd[d] = oor ? 32'd0 : mdl[d][idx[9:0]];
        end else if (!oor) begin
            for (int i = 0; i < 4; i++) begin
                if (w[i]) mdl[d][idx[9:0]][8*i +: 8] = data[8*i +: 8];
            end
        end
        chk("rdata", rd[d], last_rd[d]);
        if (!hold) en[d] = 1'b0;
    endtask

    initial begin
        int k;
        bit seen;
        logic [31:0] old;
        logic [31:0] a;
        logic [3:0]  w;
        n_checks = 0;
        n_errors = 0;
        wt[0] = 0;
        wt[1] = 3;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; en[d] = 1'b1; wen[d] = 4'd0;
            addr[d] = 32'd0; wd[d] = 32'd0; last_rd[d] = 32'd0;
        end

        // Reset state, with MemEnable asserted to prove rst masks MemStall.
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_stall", {31'd0, stall[d]}, 32'd0);
            chk("rst_valid", {31'd0, vld[d]}, 32'd0);
            chk("rst_err",   {31'd0, err[d]}, 32'd0);
            chk("rst_rdata", rd[d], 32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            en[d]  = 1'b0;
        end

        // Preload words 0..63 and 1023 of both RAMs.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) access(d, 4'hF, 32'(i * 4), $urandom, 1'b0);
            access(d, 4'hF, 32'h0000_0FFC, $urandom, 1'b0);
        end

        // Zero-wait write then read of 0x10.
        access(0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        access(0, 4'h0, 32'h10, 32'h0, 1'b0);
        chk("t1_read", rd[0], 32'hDEADBEEF);

        // Byte-lane merges on both DUTs.
        for (int d = 0; d < 2; d++) begin
            access(d, 4'hF,    32'h20, 32'h11223344, 1'b0);
            access(d, 4'b0100, 32'h22, 32'hAAAAAAAA, 1'b0);
            access(d, 4'h0,    32'h20, 32'h0, 1'b0);
            chk("lane2_merge", rd[d], 32'h11AA3344);
            access(d, 4'b0011, 32'h20, 32'h55555555, 1'b0);
            access(d, 4'h0,    32'h20, 32'h0, 1'b0);
            chk("lane01_merge", rd[d], 32'h11AA5555);
        end

        // Back-to-back with MemEnable held: each access costs WAIT_CYCLES+1 stalls.
        access(1, 4'hF, 32'h30, 32'hCAFEF00D, 1'b1);
        access(1, 4'h0, 32'h30, 32'h0, 1'b1);
        chk("b2b_read", rd[1], 32'hCAFEF00D);
        access(1, 4'h0, 32'h20, 32'h0, 1'b0);
        chk("b2b_read2", rd[1], 32'h11AA5555);

        // Out-of-range write/read and the last valid word.
        access(0, 4'hF, 32'h1000, 32'hFFFFFFFF, 1'b0);
        access(0, 4'h0, 32'h1000, 32'h0, 1'b0);
        chk("oor_read_zero", rd[0], 32'h0);
        access(0, 4'hF, 32'h0FFC, 32'h0BADF00D, 1'b0);
        access(0, 4'h0, 32'h0FFC, 32'h0, 1'b0);
        chk("last_word", rd[0], 32'h0BADF00D);

        // Reset during BUSY aborts the write.
        old = mdl[1][4];
        @(negedge clk);
        en[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'h10; wd[1] = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        chk("rst_busy_stall", {31'd0, stall[1]}, 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        en[1]  = 1'b0;
        last_rd[1] = 32'd0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (vld[1] === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_abort_novalid", {31'd0, seen}, 32'd0);
        chk("rst_abort_rdata", rd[1], 32'd0);
        access(1, 4'h0, 32'h10, 32'h0, 1'b0);
        chk("rst_abort_old", rd[1], old);

        // Inputs change mid-BUSY and MemEnable drops: captured write still lands.
        @(negedge clk);
        en[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'h40; wd[1] = 32'hA5A55A5A;
        @(negedge clk);
        wen[1] = 4'h0; addr[1] = 32'h44; wd[1] = 32'h0;
        @(negedge clk);
        en[1] = 1'b0;
        #1;
        chk("drop_stall", {31'd0, stall[1]}, 32'd0);
        k = 0;
        while (vld[1] !== 1'b1 && k < 10) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drop_valid", {31'd0, vld[1]}, 32'd1);
        chk("drop_valid_cycle", 32'(k), 32'd2);
        mdl[1][16] = 32'hA5A55A5A;
        access(1, 4'h0, 32'h40, 32'h0, 1'b0);
        access(1, 4'h0, 32'h44, 32'h0, 1'b0);

        // Randomised mix of reads, partial writes and out-of-range accesses.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 300; n++) begin
                case ($urandom_range(0, 9))
                    0:       a = $urandom | 32'h0000_1000;
                    1:       a = 32'h0000_0FFC | 32'($urandom_range(0, 3));
                    default: a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
                endcase
                w = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom);
                access(d, w, a, $urandom, (n != 299) && ($urandom_range(0, 1) == 1));
            end
        end

        // Sweep: no word was disturbed by anything above.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) access(d, 4'h0, 32'(i * 4), 32'h0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
